// File: rtl/uart_receive.sv
// uart_receive: 8N1 serial-to-parallel UART receiver.
//
// Synchronises the asynchronous serial line, samples every bit at mid-symbol
// and hands each received byte to the consumer over a valid/ready handshake.
// Framing errors (stop bit sampled low) and overruns are reported.
//
// Ports:
//   Clock         system clock, rising-edge active
//   Reset         asynchronous, active-low reset
//   SIn           serial input, asynchronous, idles high
//   DataOut       received byte, stable while DataOutValid is high
//   DataOutValid  byte available, held until accepted
//   DataOutReady  consumer accepts the byte when high with DataOutValid
//   FramingError  one-cycle pulse when the stop bit is sampled low
//   Overrun       sticky: a byte completed while the previous one was pending
module uart_receive #(
    parameter int ClockFreq = 100_000_000,
    parameter int BaudRate  = 115_200
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       SIn,
    output logic [7:0] DataOut,
    output logic       DataOutValid,
    input  logic       DataOutReady,
    output logic       FramingError,
    output logic       Overrun
);

    localparam int SymbolEdgeTime    = ClockFreq / BaudRate;
    localparam int SampleTime        = SymbolEdgeTime / 2;
    localparam int ClockCounterWidth = $clog2(SymbolEdgeTime);

    localparam logic [ClockCounterWidth-1:0] SampleCount =
        ClockCounterWidth'(SampleTime - 1);
    localparam logic [ClockCounterWidth-1:0] LastCount =
        ClockCounterWidth'(SymbolEdgeTime - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAITIDLE
    } state_e;

    state_e                         state_q, state_d;
    logic                           sync1_q, sync1_d;
    logic                           sync2_q, sync2_d;
    logic [ClockCounterWidth-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]                     bit_cnt_q, bit_cnt_d;
    logic [7:0]                     shift_q, shift_d;
    logic [7:0]                     data_q, data_d;
    logic                           valid_q, valid_d;
    logic                           fe_q, fe_d;
    logic                           overrun_q, overrun_d;

    logic sin_sync;
    logic sample;
    logic accept;

    assign sin_sync = sync2_q;
    assign sample   = (clk_cnt_q == SampleCount);
    assign accept   = valid_q & DataOutReady;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fe_q      <= fe_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        sync1_d   = SIn;
        sync2_d   = sync1_q;
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        fe_d      = 1'b0;
        overrun_d = overrun_q;

        if (accept) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (!sin_sync) begin
                    state_d = START;
                end
            end
            START: begin
                if (sample) begin
                    bit_cnt_d = '0;
                    state_d   = sin_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample) begin
                    shift_d[bit_cnt_q] = sin_sync;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (sample) begin
                    if (sin_sync) begin
                        // Back to IDLE at mid-stop so a following start bit
                        // with no idle gap is still caught on time.
                        state_d = IDLE;
                        if (!valid_q || accept) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        fe_d    = 1'b1;
                        state_d = WAITIDLE;
                    end
                end
            end
            WAITIDLE: begin
                // A held-low line (break) must not restart frames.
                if (sin_sync) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The first low cycle seen in IDLE counts as 0, so the counter is
        // already 1 on the first START cycle and the sample strobe lands
        // SampleTime-1 cycles after that first low cycle.
        if (state_q == IDLE) begin
            clk_cnt_d = (state_d != IDLE) ? ClockCounterWidth'(1) : '0;
        end else if (clk_cnt_q == LastCount) begin
            clk_cnt_d = '0;
        end else begin
            clk_cnt_d = clk_cnt_q + ClockCounterWidth'(1);
        end
    end

    assign DataOut      = data_q;
    assign DataOutValid = valid_q;
    assign FramingError = fe_q;
    assign Overrun      = overrun_q;

endmodule

// File: tb/tb_uart_receive.sv
// tb_uart_receive: directed bench for uart_receive at 10 clocks per bit.
// A frame-level model predicts when each byte or framing error must appear
// and a per-cycle compare checks the outputs against it.
module tb_uart_receive;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       SIn = 1'b1;
    logic       DataOutReady = 1'b1;
    logic [7:0] DataOut;
    logic       DataOutValid;
    logic       FramingError;
    logic       Overrun;

    uart_receive #(
        .ClockFreq(100),
        .BaudRate (10)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .SIn         (SIn),
        .DataOut     (DataOut),
        .DataOutValid(DataOutValid),
        .DataOutReady(DataOutReady),
        .FramingError(FramingError),
        .Overrun     (Overrun)
    );

    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Pin edge of start bit -> output edge: 2 sync flops, stop sample at
    // t0+94, registered result one cycle later.
    localparam int FrameLatency = 97;

    typedef struct {
        int         at;
        bit         fe;
        logic [7:0] data;
    } ev_t;

    typedef struct {
        int         at;
        logic [7:0] data;
    } rise_t;

    ev_t   ev_q[$];
    rise_t rise_q[$];

    logic       m_valid = 1'b0;
    logic       m_fe    = 1'b0;
    logic       m_over  = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       prev_v  = 1'b0;
    int         fe_cnt  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level model: events scheduled by the sender fire at their edge.
    initial begin
        forever begin
            @(posedge Clock or negedge Reset);
            if (!Reset) begin
                m_valid = 1'b0;
                m_fe    = 1'b0;
                m_over  = 1'b0;
                m_data  = 8'h00;
                ev_q.delete();
            end else begin
                cyc  = cyc + 1;
                m_fe = 1'b0;
                if (m_valid && DataOutReady) m_valid = 1'b0;
                if (ev_q.size() > 0 && ev_q[0].at == cyc) begin
                    ev_t e;
                    e = ev_q.pop_front();
                    if (e.fe) begin
                        m_fe = 1'b1;
                    end else if (!m_valid) begin
                        m_valid = 1'b1;
                        m_data  = e.data;
                    end else begin
                        m_over = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle compare and beat monitor.
    initial begin
        forever begin
            @(negedge Clock);
            check("valid", int'(DataOutValid), int'(m_valid));
            if (m_valid) check("data", int'(DataOut), int'(m_data));
            check("framing_error", int'(FramingError), int'(m_fe));
            check("overrun", int'(Overrun), int'(m_over));
            if (DataOutValid && !prev_v) begin
                rise_t r;
                r.at   = cyc;
                r.data = DataOut;
                rise_q.push_back(r);
            end
            prev_v = DataOutValid;
            if (FramingError) fe_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic idle(input logic v, input int n);
        SIn = v;
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    // Drives one frame starting just after the current edge; cut>0 stops
    // driving after that many cycles (no outcome scheduled).
    task automatic send(input logic [7:0] b, input logic stop, input int cut, output int p);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        p    = cyc;
        if (cut == 0) begin
            ev_t e;
            e.at   = p + FrameLatency;
            e.fe   = !stop;
            e.data = b;
            ev_q.push_back(e);
        end
        for (int k = 0; k < 100; k++) begin
            if (cut != 0 && k == cut) break;
            SIn = bits[k/10];
            @(posedge Clock);
            #1;
        end
    endtask

    int p, p2, fe0;

    initial begin
        repeat (3) @(posedge Clock);
        #1;
        check("reset_valid", int'(DataOutValid), 0);
        check("reset_data", int'(DataOut), 0);
        check("reset_fe", int'(FramingError), 0);
        check("reset_overrun", int'(Overrun), 0);
        Reset = 1'b1;
        idle(1'b1, 5);

        // Single byte
        rise_q.delete();
        send(8'hA5, 1'b1, 0, p);
        idle(1'b1, 20);
        check("single_beats", rise_q.size(), 1);
        if (rise_q.size() >= 1) begin
            check("single_latency_from_t0", rise_q[0].at - (p + 2), 95);
            check("single_data", int'(rise_q[0].data), 'hA5);
        end
        check("single_no_fe", fe_cnt, 0);

        // Back-to-back
        rise_q.delete();
        send(8'h00, 1'b1, 0, p);
        send(8'hFF, 1'b1, 0, p2);
        idle(1'b1, 20);
        check("b2b_beats", rise_q.size(), 2);
        if (rise_q.size() >= 2) begin
            check("b2b_spacing", rise_q[1].at - rise_q[0].at, 100);
            check("b2b_data0", int'(rise_q[0].data), 'h00);
            check("b2b_data1", int'(rise_q[1].data), 'hFF);
        end

        // Backpressure / overrun
        DataOutReady = 1'b0;
        rise_q.delete();
        send(8'h3C, 1'b1, 0, p);
        send(8'h81, 1'b1, 0, p2);
        idle(1'b1, 10);
        check("bp_data_held", int'(DataOut), 'h3C);
        check("bp_valid_held", int'(DataOutValid), 1);
        check("bp_overrun", int'(Overrun), 1);
        check("bp_beats", rise_q.size(), 1);
        DataOutReady = 1'b1;
        @(posedge Clock);
        #1;
        check("bp_valid_after_accept", int'(DataOutValid), 0);
        idle(1'b1, 5);

        // Framing error followed by a held-low line
        fe0 = fe_cnt;
        rise_q.delete();
        send(8'h55, 1'b0, 0, p);
        idle(1'b0, 50);
        idle(1'b1, 150);
        check("fe_pulses", fe_cnt - fe0, 1);
        check("fe_no_beat", rise_q.size(), 0);

        // Glitch rejection
        fe0 = fe_cnt;
        rise_q.delete();
        idle(1'b0, 3);
        idle(1'b1, 30);
        check("glitch_no_beat", rise_q.size(), 0);
        check("glitch_no_fe", fe_cnt - fe0, 0);
        send(8'h12, 1'b1, 0, p);
        idle(1'b1, 20);
        check("glitch_then_beats", rise_q.size(), 1);
        if (rise_q.size() >= 1) check("glitch_then_data", int'(rise_q[0].data), 'h12);

        // Asynchronous reset mid data bit 4
        send(8'hE7, 1'b1, 55, p);
        Reset = 1'b0;
        SIn   = 1'b1;
        #1;
        check("areset_valid", int'(DataOutValid), 0);
        check("areset_data", int'(DataOut), 0);
        check("areset_fe", int'(FramingError), 0);
        check("areset_overrun", int'(Overrun), 0);
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b1;
        idle(1'b1, 10);
        rise_q.delete();
        send(8'hC3, 1'b1, 0, p);
        idle(1'b1, 20);
        check("post_reset_beats", rise_q.size(), 1);
        if (rise_q.size() >= 1) check("post_reset_data", int'(rise_q[0].data), 'hC3);
        check("post_reset_overrun", int'(Overrun), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_receive.md
Name: uart_receive

Overview:
- Serial-to-parallel UART receiver. It is the receive-side counterpart of the existing 8N1 UART transmitter.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Synchronises the asynchronous serial input, samples each bit at mid-symbol, and presents each received byte on a valid/ready handshake to the consumer (host FIFO or bus bridge).
- Reports framing errors and overruns.

Parameters:
- ClockFreq, 100_000_000, system clock frequency in Hz.
- BaudRate, 115_200, serial bit rate in baud.
- SymbolEdgeTime (local), ClockFreq/BaudRate, clocks per bit.
- SampleTime (local), SymbolEdgeTime/2, clocks from bit edge to sample point.
- ClockCounterWidth (local), log2(SymbolEdgeTime), width of the bit-period counter.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset (asserted when 0).
- SIn  input  1  serial line, asynchronous to Clock, idles high.
- DataOut  output  8  received byte; stable while DataOutValid=1.
- DataOutValid  output  1  byte available; held until accepted.
- DataOutReady  input  1  consumer accepts the byte on a cycle where DataOutValid=1 and DataOutReady=1.
- FramingError  output  1  one-cycle pulse when the stop bit is sampled as 0.
- Overrun  output  1  sticky flag: a byte completed while the previous one was unaccepted.

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=IDLE, counters=0, synchroniser flops=1.
  - DataOut=8'h00, DataOutValid=0, FramingError=0, Overrun=0.
  - Reset mid-frame aborts the frame immediately; no partial byte is delivered.
- Synchroniser: SIn passes through 2 flops; SInSync is the second flop. All decisions use SInSync, so there is 2 cycles of latency from the pin.
- ClockCounter:
  - Cleared on the cycle the state leaves IDLE.
  - Otherwise increments while not IDLE and wraps to 0 at SymbolEdgeTime-1.
  - The sample strobe fires when ClockCounter==SampleTime-1.
- State machine (IDLE, START, DATA, STOP, WAITIDLE):
  - IDLE: SInSync=0 -> START. Call the first cycle with SInSync=0 "t0".
  - START: on the sample strobe (t0+SampleTime-1), SInSync=0 -> DATA with BitCounter=0; SInSync=1 -> IDLE (glitch rejected, nothing reported).
  - DATA: on each sample strobe, shift SInSync into bit BitCounter of the shift register (LSB first) and increment BitCounter. After bit 7 is sampled -> STOP.
  - STOP: on the sample strobe, SInSync=1 -> frame good, go to IDLE. SInSync=0 -> pulse FramingError for 1 cycle, discard the byte, go to WAITIDLE.
  - WAITIDLE: stay until SInSync=1, then go to IDLE. This prevents a held-low line (break) from restarting frames.
- Sample timing: data bit i is sampled at t0+SampleTime-1+SymbolEdgeTime*(i+1); the stop bit at t0+SampleTime-1+9*SymbolEdgeTime.
- Good frame delivery:
  - If DataOutValid=0, or it is being accepted that same cycle, DataOut takes the byte and DataOutValid=1 on the next cycle. This is 1 cycle after the stop sample.
  - Otherwise the new byte is dropped, DataOut is left unchanged, and Overrun is set.
- Returning to IDLE at mid-stop lets back-to-back frames be received with no idle gap.
- Handshake: DataOutValid clears on the cycle after acceptance. DataOut must not change while DataOutValid=1 and the byte is unaccepted.
- Overrun clears only on reset.
- FramingError and good-frame delivery are mutually exclusive.

Test Plan:
All scenarios use ClockFreq=100, BaudRate=10, so SymbolEdgeTime=10 and SampleTime=5.
- Single byte: drive frame 8'hA5 at 10 clocks/bit with DataOutReady=1 -> DataOutValid rises exactly 95 cycles after t0, DataOut=8'hA5 for 1 cycle, FramingError=0, Overrun=0.
- Back-to-back: send 8'h00 then 8'hFF with no idle gap -> two valid beats, 8'h00 then 8'hFF, spaced 100 cycles apart.
- Backpressure/overrun: DataOutReady=0; send 8'h3C then 8'h81 -> DataOut stays 8'h3C, Overrun=1 after the second stop sample. Raise DataOutReady -> one beat of 8'h3C, then DataOutValid=0.
- Framing error: send 8'h55 with the stop bit driven 0 and the line then held low for 50 clocks -> FramingError pulses 1 cycle, no valid beat, and no new frame starts until the line returns high.
- Glitch rejection: pulse SIn low for 3 clocks -> returns to IDLE, no outputs change. Then send a normal 8'h12 -> received correctly.
- Async reset: assert Reset=0 mid-way through data bit 4 of a frame -> all outputs 0 immediately. Release Reset, then send a clean 8'hC3 -> DataOut=8'hC3 with no residue from the aborted frame.
